ysyx_22050854_div_ctrl: RTL and testbench

Sequencing controller between the EXU and the iterative divider (`ysyx_22050854_divider_1`). It accepts RV64M divide/remainder requests, resolves divide-by-zero and signed-overflow cases locally in one cycle, and issues all other requests to the divider with a single-cycle `div_valid` pulse. It captures the divider's one-cycle result pulse and holds the formatted result until the pipeline takes it. On a flush it discards any in-flight result, because the divider itself cannot abort.

---
 rtl/ysyx_22050854_div_ctrl.sv | 141 ++++++++++++++
 tb/tb_ysyx_22050854_div_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_div_ctrl.sv
// Sequencing controller between the EXU and the iterative divider.
// Divide-by-zero and signed overflow are resolved here; all other requests go to the divider.
module ysyx_22050854_div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_word,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        busy,
    input  logic        flush,
    output logic        div_valid,
    output logic [63:0] div_dividend,
    output logic [63:0] div_divisor,
    output logic        div_divw,
    output logic        div_signed,
    input  logic        div_ready,
    input  logic        div_out_valid,
    input  logic [63:0] div_quotient,
    input  logic [63:0] div_remainder
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        word_q, word_d;
    logic [63:0] dividend_q, dividend_d;
    logic [63:0] divisor_q, divisor_d;
    logic [63:0] resp_data_q, resp_data_d;

    logic [63:0] eff_src1, eff_src2;
    logic        div_zero, sign_ovf;

    // Word results are always re-extended from bit 31.
    function automatic logic [63:0] fmt(input logic word, input logic [63:0] r);
        return word ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    always_comb begin
        eff_src1 = req_word ? {32'b0, req_src1[31:0]} : req_src1;
        eff_src2 = req_word ? {32'b0, req_src2[31:0]} : req_src2;
        div_zero = (eff_src2 == 64'b0);
        if (req_word) begin
            sign_ovf = ~req_op[0] & (req_src1[31:0] == 32'h8000_0000)
                     & (req_src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            sign_ovf = ~req_op[0] & (req_src1 == 64'h8000_0000_0000_0000)
                     & (req_src2 == 64'hFFFF_FFFF_FFFF_FFFF);
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d       = req_op;
                    word_d     = req_word;
                    dividend_d = req_src1;
                    divisor_d  = req_src2;
                    if (div_zero) begin
                        resp_data_d = req_op[1] ? fmt(req_word, eff_src1) : 64'hFFFF_FFFF_FFFF_FFFF;
                        state_d     = StDone;
                    end else if (sign_ovf) begin
                        resp_data_d = req_op[1] ? 64'b0 : fmt(req_word, eff_src1);
                        state_d     = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                // A flush on the pulse cycle still leaves a divide in flight.
                if (flush) begin
                    state_d = div_ready ? StDrain : StIdle;
                end else if (div_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = StDrain;
                end else if (div_out_valid) begin
                    resp_data_d = fmt(word_q, op_q[1] ? div_remainder : div_quotient);
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (div_out_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= 2'b0;
            word_q      <= 1'b0;
            dividend_q  <= 64'b0;
            divisor_q   <= 64'b0;
            resp_data_q <= 64'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_q      <= word_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign resp_valid   = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign div_valid    = (state_q == StIssue) & div_ready;
    assign resp_data    = resp_data_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign div_divw     = word_q;
    assign div_signed   = ~op_q[0];

endmodule

// File: tb/tb_ysyx_22050854_div_ctrl.sv
// Directed bench for the divider controller with a behavioural divider and a result scoreboard.
module tb_ysyx_22050854_div_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_word;
    logic [1:0]  req_op;
    logic [63:0] req_src1, req_src2;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_data;
    logic        busy, flush;
    logic        div_valid, div_divw, div_signed, div_ready, div_out_valid;
    logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;

    always #5 clock = ~clock;

    ysyx_22050854_div_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_word     (req_word),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .busy         (busy),
        .flush        (flush),
        .div_valid    (div_valid),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_divw     (div_divw),
        .div_signed   (div_signed),
        .div_ready    (div_ready),
        .div_out_valid(div_out_valid),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder)
    );

    // Behavioural divider: fixed latency, upper 32 bits of word results forced to 0.
    localparam int Lat = 6;
    int          cnt;
    logic        ready_en;
    logic [63:0] pend_q, pend_r;
    logic        cap_divw, cap_signed;

    assign div_ready = (cnt == 0) && ready_en;

    always @(posedge clock) begin
        div_out_valid <= 1'b0;
        if (reset) begin
            cnt           <= 0;
            div_quotient  <= 64'b0;
            div_remainder <= 64'b0;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                div_out_valid <= 1'b1;
                div_quotient  <= pend_q;
                div_remainder <= pend_r;
            end
        end else if (div_valid) begin
            cnt        <= Lat;
            cap_divw   <= div_divw;
            cap_signed <= div_signed;
            if (div_divw && div_signed) begin
                pend_q <= {32'b0, 32'($signed(div_dividend[31:0]) / $signed(div_divisor[31:0]))};
                pend_r <= {32'b0, 32'($signed(div_dividend[31:0]) % $signed(div_divisor[31:0]))};
            end else if (div_divw) begin
                pend_q <= {32'b0, div_dividend[31:0] / div_divisor[31:0]};
                pend_r <= {32'b0, div_dividend[31:0] % div_divisor[31:0]};
            end else if (div_signed) begin
                pend_q <= $signed(div_dividend) / $signed(div_divisor);
                pend_r <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                pend_q <= div_dividend / div_divisor;
                pend_r <= div_dividend % div_divisor;
            end
        end
    end

    // Protocol monitors.
    int   pulse_cnt = 0;
    int   viol = 0;
    logic dv_prev = 1'b0;
    always @(posedge clock) begin
        if (div_valid) pulse_cnt++;
        if (div_valid && dv_prev) viol++;
        if (div_out_valid && (req_ready || resp_valid)) viol++;
        dv_prev <= div_valid;
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input logic special);
        @(negedge clock);
        check("req_ready", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_word  = word;
        req_src1  = a;
        req_src2  = b;
        @(posedge clock);
        sb_q.push_back(exp);
        @(negedge clock);
        req_valid = 1'b0;
        check("lat_resp_valid", {63'b0, resp_valid}, {63'b0, special});
        if (!special && ready_en) check("lat_div_valid", {63'b0, div_valid}, 64'd1);
    endtask

    task automatic get_resp(input string tag, input int hold);
        int          k;
        logic [63:0] exp, d0;
        k = 0;
        while (!resp_valid && k < 200) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_valid"}, {63'b0, resp_valid}, 64'd1);
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                exp = sb_q.pop_front();
                check(tag, resp_data, exp);
            end
            d0 = resp_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                check({tag, "_hold"}, {resp_data[62:0], resp_valid}, {d0[62:0], 1'b1});
            end
            resp_ready = 1'b1;
            @(negedge clock);
            resp_ready = 1'b0;
            check({tag, "_idle"}, {63'b0, req_ready}, 64'd1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clock);
            k++;
        end
        check(tag, {62'b0, busy, resp_valid}, 64'd0);
    endtask

    int p0;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
        req_src1 = 64'b0; req_src2 = 64'b0; resp_ready = 1'b0; flush = 1'b0; ready_en = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_outputs", {59'b0, req_ready, resp_valid, busy, div_valid, div_divw}, 64'h10);
        check("rst_resp_data", resp_data, 64'b0);
        check("rst_dividend", div_dividend, 64'b0);

        // DIVW -7 / 2
        p0 = pulse_cnt;
        do_req(2'd0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        get_resp("divw", 0);
        check("divw_pulses", 64'(pulse_cnt - p0), 64'd1);
        check("divw_flags", {62'b0, cap_divw, cap_signed}, 64'd3);

        // REMW -7 / 2, model leaves upper remainder bits zero
        do_req(2'd2, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        get_resp("remw", 0);

        // Divide-by-zero and overflow: resolved locally
        p0 = pulse_cnt;
        do_req(2'd1, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        get_resp("divu_zero", 0);
        do_req(2'd2, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1);
        get_resp("rem_zero", 0);
        do_req(2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b1);
        get_resp("div_ovf", 0);
        do_req(2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        get_resp("remw_ovf", 0);
        check("special_no_pulse", 64'(pulse_cnt - p0), 64'd0);

        // Flush in WAIT -> DRAIN until the divider result arrives
        do_req(2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0);
        void'(sb_q.pop_back());
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("drain_state", {62'b0, busy, resp_valid}, 64'd2);
        wait_idle("drain_exit");
        do_req(2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0);
        get_resp("divu_after_flush", 0);

        // Flush in ISSUE before the pulse
        p0 = pulse_cnt;
        ready_en = 1'b0;
        do_req(2'd0, 1'b0, 64'd50, 64'd3, 64'd16, 1'b0);
        void'(sb_q.pop_back());
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        ready_en = 1'b1;
        check("issue_flush_idle", {62'b0, busy, req_ready}, 64'd1);
        @(negedge clock);
        check("issue_flush_no_pulse", 64'(pulse_cnt - p0), 64'd0);

        // Flush in DONE drops the result
        do_req(2'd1, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        void'(sb_q.pop_back());
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("done_flush_idle", {62'b0, busy, resp_valid}, 64'd0);

        // Divider not ready for 5 cycles, then one pulse; response held 3 cycles
        p0 = pulse_cnt;
        ready_en = 1'b0;
        do_req(2'd0, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("stall_no_pulse", {63'b0, div_valid}, 64'd0);
            @(negedge clock);
        end
        check("stall_no_pulse", {63'b0, div_valid}, 64'd0);
        ready_en = 1'b1;
        #1;
        check("stall_pulse", {63'b0, div_valid}, 64'd1);
        @(negedge clock);
        check("stall_pulse_end", {63'b0, div_valid}, 64'd0);
        get_resp("div_stall", 3);
        check("stall_pulses", 64'(pulse_cnt - p0), 64'd1);

        // Back-to-back REMU
        do_req(2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0);
        get_resp("remu", 0);

        repeat (2) @(negedge clock);
        check("protocol_violations", 64'(viol), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
